// File: rtl/sd_adc_pkg.sv
// Shared constants for the sigma-delta ADC receiver.
// SD_ADC_AVG_EN (in sd_adc_rx) uses AVG_TAPS/AVG_SHIFT for the moving average.
package sd_adc_pkg;

  localparam int unsigned DECIM_DEFAULT = 256;
  localparam int unsigned AVG_TAPS      = 4;
  localparam int unsigned AVG_SHIFT     = $clog2(AVG_TAPS);

  // Sample width able to hold a full-window count of 0..decim
  function automatic int unsigned sample_width(input int unsigned decim);
    return $clog2(decim + 1);
  endfunction

endpackage

// File: rtl/sd_adc_sync.sv
// Two-flop synchroniser for asynchronous single-bit board inputs.
module sd_adc_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sd_adc_rx.sv
// Sigma-delta ADC receiver: feedback bitstream, ones-count decimation, valid/ready sample.
// Define SD_ADC_AVG_EN to pass each window count through a 4-tap moving average.
module sd_adc_rx
  import sd_adc_pkg::*;
#(
  parameter  int unsigned DECIM = DECIM_DEFAULT,
  localparam int unsigned SW    = sample_width(DECIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cmp_in,
  output logic          fb_out,
  output logic [SW-1:0] sample,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          overrun,
  input  logic          ovr_clr
);

  localparam logic [SW-1:0] WIN_LAST = SW'(DECIM - 1);

  logic s2;

  sd_adc_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cmp_in),
    .q_o (s2)
  );

  // Feedback is the synchroniser flop itself, no logic in between
  assign fb_out = s2;

  logic [SW-1:0] win_q, win_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] raw_c;
  logic          win_end_c;

  always_comb begin
    win_end_c = en && (win_q == WIN_LAST);
    raw_c     = acc_q + SW'(s2);
    win_d     = '0;
    acc_d     = '0;
    if (en && !win_end_c) begin
      win_d = win_q + SW'(1);
      acc_d = raw_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
      acc_q <= '0;
    end else begin
      win_q <= win_d;
      acc_q <= acc_d;
    end
  end

  logic          load_c;
  logic [SW-1:0] load_val_c;

`ifdef SD_ADC_AVG_EN
  localparam int unsigned HW   = AVG_TAPS - 1;
  localparam int unsigned SUMW = SW + AVG_SHIFT;

  logic [SW-1:0]   hist_q [HW];
  logic [SW-1:0]   hist_d [HW];
  logic [SW-1:0]   avg_q, avg_d;
  logic            pend_q, pend_d;
  logic [SUMW-1:0] sum_c;

  // Average computed on the window edge, handed to the holding register one cycle later
  always_comb begin
    sum_c = SUMW'(raw_c);
    for (int i = 0; i < HW; i++) begin
      sum_c = sum_c + SUMW'(hist_q[i]);
    end
    hist_d = hist_q;
    avg_d  = avg_q;
    pend_d = win_end_c;
    if (win_end_c) begin
      hist_d[0] = raw_c;
      for (int i = 1; i < HW; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      avg_d = SW'(sum_c >> AVG_SHIFT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HW; i++) begin
        hist_q[i] <= '0;
      end
      avg_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      avg_q  <= avg_d;
      pend_q <= pend_d;
    end
  end

  assign load_c     = pend_q;
  assign load_val_c = avg_q;
`else
  assign load_c     = win_end_c;
  assign load_val_c = raw_c;
`endif

  logic [SW-1:0] sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          ovr_evt_c;

  // Holding register and handshake; a new result always wins over a transfer
  always_comb begin
    ovr_evt_c = load_c && valid_q && !sample_ready;
    sample_d  = sample_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    if (load_c) begin
      sample_d = load_val_c;
      valid_d  = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    if (ovr_evt_c) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_sd_adc_rx.sv
// Testbench for sd_adc_rx (DECIM=16): directed table, corner sequences and random run vs a window model.
module tb_sd_adc_rx;

  localparam int DECIM = 16;
  localparam int SW    = 5;
`ifdef SD_ADC_AVG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, cmp_in, sample_ready, ovr_clr;
  logic          fb_out, sample_valid, overrun;
  logic [SW-1:0] sample;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sd_adc_rx #(.DECIM(DECIM)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cmp_in       (cmp_in),
    .fb_out       (fb_out),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .ovr_clr      (ovr_clr)
  );

  // Reference model: comparator stream delayed two edges, ones counted per full window
  bit pipe[$];
  int m_cnt, m_ones;
  int m_hist[$];
  bit pend;
  int pend_val;
  bit mv, mo;
  int ms;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(1'b0);
    pipe.push_back(1'b0);
    m_cnt = 0; m_ones = 0;
    m_hist.delete();
    pend = 0; pend_val = 0;
    mv = 0; mo = 0; ms = 0;
  endtask

  task automatic model_edge(input bit e, input bit c, input bit r, input bit k);
    bit s2_old, have, ovr;
    int val, s;
    s2_old = pipe.pop_front();
    pipe.push_back(c);
    have = 0; val = 0; s = 0;
`ifdef SD_ADC_AVG_EN
    if (pend) begin have = 1; val = pend_val; end
    pend = 0;
`endif
    if (e) begin
      m_ones += int'(s2_old);
      m_cnt++;
      if (m_cnt == DECIM) begin
`ifdef SD_ADC_AVG_EN
        m_hist.push_front(m_ones);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        foreach (m_hist[i]) s += m_hist[i];
        pend = 1;
        pend_val = s / 4;
`else
        have = 1;
        val = m_ones;
`endif
        m_cnt = 0; m_ones = 0;
      end
    end else begin
      m_cnt = 0; m_ones = 0;
    end
    ovr = have && mv && !r;
    if (have) begin mv = 1; ms = val; end
    else if (mv && r) mv = 0;
    mo = ovr ? 1'b1 : (k ? 1'b0 : mo);
  endtask

  function automatic bit load_next(input bit e);
`ifdef SD_ADC_AVG_EN
    return pend;
`else
    return e && (m_cnt == DECIM - 1);
`endif
  endfunction

  task automatic cycle(input bit e, input bit c, input bit r, input bit k);
    en = e; cmp_in = c; sample_ready = r; ovr_clr = k;
    @(posedge clk);
    model_edge(e, c, r, k);
    #1;
    check("sample_valid", 32'(sample_valid), int'(mv));
    check("sample", 32'(sample), ms);
    check("overrun", 32'(overrun), int'(mo));
    check("fb_out", 32'(fb_out), int'(pipe[0]));
  endtask

  // Asserted asynchronously; outputs must clear before any clock edge
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cmp_in = 1'b0; sample_ready = 1'b1; ovr_clr = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_sample", 32'(sample), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_fb_out", 32'(fb_out), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int                  mode;  // 0 hold low, 1 hold high, 2 toggle starting high
    logic [0:3][SW-1:0]  exp;
  } scen_t;

  scen_t scen[3];
  int    got[$];
  int    rise[$];

  initial begin
    bit c, k, found;
    int j;

`ifdef SD_ADC_AVG_EN
    scen[0].mode = 1; scen[0].exp = {5'd3, 5'd7, 5'd11, 5'd15};
    scen[1].mode = 0; scen[1].exp = {5'd0, 5'd0, 5'd0, 5'd0};
    scen[2].mode = 2; scen[2].exp = {5'd1, 5'd3, 5'd5, 5'd7};
`else
    scen[0].mode = 1; scen[0].exp = {5'd14, 5'd16, 5'd16, 5'd16};
    scen[1].mode = 0; scen[1].exp = {5'd0, 5'd0, 5'd0, 5'd0};
    scen[2].mode = 2; scen[2].exp = {5'd7, 5'd8, 5'd8, 5'd8};
`endif

    // Directed table: constant and toggling comparator from reset
    foreach (scen[s]) begin
      do_reset();
      got.delete(); rise.delete();
      for (int i = 0; i < 5 * DECIM; i++) begin
        c = (scen[s].mode == 1) ? 1'b1 : (scen[s].mode == 2) ? ((i % 2) == 0) : 1'b0;
        cycle(1'b1, c, 1'b1, 1'b0);
        if (sample_valid === 1'b1) begin
          got.push_back(int'(sample));
          rise.push_back(i);
        end
      end
      check("tbl_nsamples", 32'(got.size() >= 4), 1);
      check("tbl_first_rise", 32'(rise.size() > 0 ? rise[0] : -1), DECIM - 1 + LAT);
      check("tbl_period", 32'(rise.size() > 1 ? rise[1] - rise[0] : -1), DECIM);
      for (int q = 0; q < 4; q++)
        check("tbl_sample", 32'(got.size() > q ? got[q] : -1), int'(scen[s].exp[q]));
    end

    // Overrun: two results with no consumer, then clear, then clear colliding with a result
    do_reset();
    for (int i = 0; i < 2 * DECIM + LAT; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_valid_held", 32'(sample_valid), 1);
`ifdef SD_ADC_AVG_EN
    check("ovr_overwritten", 32'(sample), 7);
`else
    check("ovr_overwritten", 32'(sample), 16);
`endif
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("ovr_cleared", 32'(overrun), 0);
    found = 0;
    for (int i = 0; i < 2 * DECIM && !found; i++) begin
      k = load_next(1'b1);
      cycle(1'b1, 1'b1, 1'b0, k);
      found = k;
    end
    check("ovr_collide_found", 32'(found), 1);
    check("ovr_set_wins", 32'(overrun), 1);

    // Async reset at win=7: partial window discarded, next sample is a full fresh window
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    j = -1;
    for (int i = 0; i < DECIM + 2 && j < 0; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      if (sample_valid === 1'b1) j = i;
    end
    check("rst7_rise", 32'(j), DECIM - 1 + LAT);
`ifdef SD_ADC_AVG_EN
    check("rst7_sample", 32'(sample), 3);
`else
    check("rst7_sample", 32'(sample), 14);
`endif

    // en dropped at win=7 then reasserted
    do_reset();
    for (int i = 0; i < DECIM + 7; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check("en_off_no_valid", 32'(sample_valid), 0);
    end
    j = -1;
    for (int i = 0; i < DECIM + 2 && j < 0; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      if (sample_valid === 1'b1) j = i;
    end
    check("en7_rise", 32'(j), DECIM - 1 + LAT);
`ifdef SD_ADC_AVG_EN
    check("en7_sample", 32'(sample), 7);
`else
    check("en7_sample", 32'(sample), 16);
`endif

`ifdef SD_ADC_AVG_EN
    // Averager step response: four zero windows, then comparator high
    do_reset();
    got.delete();
    for (int i = 0; i < 9 * DECIM + 1; i++) begin
      cycle(1'b1, i >= 4 * DECIM, 1'b1, 1'b0);
      if (sample_valid === 1'b1) got.push_back(int'(sample));
    end
    check("avg_nsamples", 32'(got.size()), 9);
    check("avg_s0", 32'(got.size() > 4 ? got[4] : -1), 3);
    check("avg_s1", 32'(got.size() > 5 ? got[5] : -1), 7);
    check("avg_s2", 32'(got.size() > 6 ? got[6] : -1), 11);
    check("avg_s3", 32'(got.size() > 7 ? got[7] : -1), 15);
    check("avg_s4", 32'(got.size() > 8 ? got[8] : -1), 16);
`endif

    // Randomised run against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 19) != 0), 1'($urandom()), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
